// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter.
// Accepts a pattern word, length and repeat count over valid/ready, then
// shifts the pattern out MSB-first with GAP_CYC idle cycles between repeats.
// Optional build macro SEQ_PATTERN_TX_ABORT_EN adds a synchronous abort input.
module seq_pattern_tx #(
  parameter int unsigned PAT_W      = 8,
  parameter int unsigned LEN_W      = $clog2(PAT_W) + 1,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned GAP_CYC    = 2,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] pat_rep,
  input  logic             pat_valid,
  output logic             pat_ready,
  output logic             o,
  output logic             o_valid,
  output logic             busy,
  output logic             done
`ifdef SEQ_PATTERN_TX_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam int unsigned IDX_W    = $clog2(PAT_W);
  localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [PAT_W-1:0]   data_q;
  logic [IDX_W-1:0]   len_m1_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   rep_q;
  logic [GAP_W-1:0]   gap_q;
  logic [IDX_W-1:0]   len_m1_c;

  // Effective length minus one; 0 or oversize lengths mean a full word
  always_comb begin
    len_m1_c = IDX_W'(PAT_W - 1);
    if ((pat_len != '0) && (pat_len <= LEN_W'(PAT_W))) begin
      len_m1_c = IDX_W'(pat_len - 1'b1);
    end
  end

  // Transmit FSM with registered serial and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      len_m1_q  <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      o         <= IDLE_LEVEL;
      o_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pat_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pat_valid && pat_ready) begin
            data_q    <= pat_data;
            len_m1_q  <= len_m1_c;
            idx_q     <= len_m1_c;
            rep_q     <= pat_rep;
            o         <= pat_data[len_m1_c];
            o_valid   <= 1'b1;
            busy      <= 1'b1;
            pat_ready <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (idx_q == '0) begin
            if (rep_q == '0) begin
              o       <= IDLE_LEVEL;
              o_valid <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              rep_q <= rep_q - 1'b1;
              idx_q <= len_m1_q;
              if (GAP_CYC == 0) begin
                o <= data_q[len_m1_q];
              end else begin
                gap_q   <= GAP_W'(GAP_LOAD);
                o       <= IDLE_LEVEL;
                o_valid <= 1'b0;
                state   <= GAP;
              end
            end
          end else begin
            idx_q <= idx_q - 1'b1;
            o     <= data_q[idx_q - 1'b1];
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            o       <= data_q[idx_q];
            o_valid <= 1'b1;
            state   <= SHIFT;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          pat_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
`ifdef SEQ_PATTERN_TX_ABORT_EN
      // Abort overrides any transition taken above while transmitting
      if (abort && ((state == SHIFT) || (state == GAP))) begin
        o         <= IDLE_LEVEL;
        o_valid   <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
        pat_ready <= 1'b1;
        state     <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed vector bench for seq_pattern_tx.
// Instance a uses GAP_CYC=2, instance b uses GAP_CYC=0; sel picks which one
// the shared stimulus drives and which outputs are checked.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic [7:0] pat_data;
  logic [3:0] pat_len;
  logic [3:0] pat_rep;
  logic       pat_valid;
  logic       abort;
  logic       sel;

  logic va, vb;
  logic ready_a, o_a, ov_a, busy_a, done_a;
  logic ready_b, o_b, ov_b, busy_b, done_b;
  logic m_ready, m_o, m_ov, m_busy, m_done;

  int pass_cnt;
  int total_cnt;

  assign va      = pat_valid & ~sel;
  assign vb      = pat_valid & sel;
  assign m_ready = sel ? ready_b : ready_a;
  assign m_o     = sel ? o_b     : o_a;
  assign m_ov    = sel ? ov_b    : ov_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;

  seq_pattern_tx #(.GAP_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .pat_data(pat_data), .pat_len(pat_len),
    .pat_rep(pat_rep), .pat_valid(va), .pat_ready(ready_a), .o(o_a),
    .o_valid(ov_a), .busy(busy_a), .done(done_a)
`ifdef SEQ_PATTERN_TX_ABORT_EN
    , .abort(abort)
`endif
  );

  seq_pattern_tx #(.GAP_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .pat_data(pat_data), .pat_len(pat_len),
    .pat_rep(pat_rep), .pat_valid(vb), .pat_ready(ready_b), .o(o_b),
    .o_valid(ov_b), .busy(busy_b), .done(done_b)
`ifdef SEQ_PATTERN_TX_ABORT_EN
    , .abort(1'b0)
`endif
  );

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  len;
    logic [3:0]  rep;
    logic        sel;
    int          n;
    logic [63:0] eo;
    logic [63:0] ev;
  } vec_t;

  vec_t vecs[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %0h required %0h", nm, $time, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!m_ready && k < 200) begin
      step();
      k++;
    end
    chk("wait_ready", 64'(m_ready), 64'd1);
  endtask

  // Issue one request, scramble inputs after acceptance, check every cycle
  task automatic run_vec(input vec_t v);
    sel = v.sel;
    #1;
    wait_ready();
    pat_data  = v.data;
    pat_len   = v.len;
    pat_rep   = v.rep;
    pat_valid = 1'b1;
    step();
    pat_valid = 1'b0;
    pat_data  = ~v.data;
    pat_len   = 4'd1;
    pat_rep   = 4'd15;
    for (int c = 0; c < v.n; c++) begin
      chk("o_valid", 64'(m_ov), 64'(v.ev[v.n-1-c]));
      chk("o", 64'(m_o), 64'(v.eo[v.n-1-c]));
      chk("busy", 64'(m_busy), 64'd1);
      chk("ready_busy", 64'(m_ready), 64'd0);
      step();
    end
    chk("done_pulse", 64'(m_done), 64'd1);
    chk("done_ov", 64'(m_ov), 64'd0);
    chk("done_busy", 64'(m_busy), 64'd1);
    chk("done_ready", 64'(m_ready), 64'd0);
    step();
    chk("post_done", 64'(m_done), 64'd0);
    chk("post_ready", 64'(m_ready), 64'd1);
    chk("post_busy", 64'(m_busy), 64'd0);
  endtask

  initial begin
    logic [2:0] e3;
    pass_cnt  = 0;
    total_cnt = 0;
    sel       = 1'b0;
    abort     = 1'b0;
    pat_valid = 1'b0;
    pat_data  = '0;
    pat_len   = '0;
    pat_rep   = '0;
    rst       = 1'b0;

    vecs[0] = '{8'h02, 4'd3, 4'd0, 1'b0, 3,  64'(3'b010), 64'(3'b111)};
    vecs[1] = '{8'h02, 4'd3, 4'd2, 1'b0, 13, 64'(13'b010_00_010_00_010),
                64'(13'b111_00_111_00_111)};
    vecs[2] = '{8'h01, 4'd1, 4'd0, 1'b0, 1,  64'(1'b1), 64'(1'b1)};
    vecs[3] = '{8'hA5, 4'd0, 4'd0, 1'b0, 8,  64'(8'hA5), 64'(8'hFF)};
    vecs[4] = '{8'h3C, 4'd9, 4'd0, 1'b0, 8,  64'(8'h3C), 64'(8'hFF)};
    vecs[5] = '{8'hF6, 4'd4, 4'd1, 1'b0, 10, 64'(10'b0110_00_0110),
                64'(10'b1111_00_1111)};
    vecs[6] = '{8'hFE, 4'd2, 4'd0, 1'b0, 2,  64'(2'b10), 64'(2'b11)};
    vecs[7] = '{8'h01, 4'd1, 4'd15, 1'b0, 46, 64'({1'b1, {15{3'b001}}}),
                64'({1'b1, {15{3'b001}}})};
    vecs[8] = '{8'hA5, 4'd0, 4'd1, 1'b1, 16, 64'(16'hA5A5), 64'(16'hFFFF)};

    // Reset state, applied asynchronously before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("rst_o", 64'(o_a), 64'd0);
    chk("rst_ov", 64'(ov_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_ready", 64'(ready_a), 64'd1);
    chk("rst_ready_b", 64'(ready_b), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    sel = 1'b0;
    #1;

    // Valid held high with new data during busy: second request waits for DONE
    wait_ready();
    e3 = 3'b010;
    pat_data = 8'h02; pat_len = 4'd3; pat_rep = 4'd0; pat_valid = 1'b1;
    step();
    pat_data = 8'hFF; pat_len = 4'd8;
    for (int c = 0; c < 3; c++) begin
      chk("hold_ov", 64'(ov_a), 64'd1);
      chk("hold_o", 64'(o_a), 64'(e3[2-c]));
      step();
    end
    chk("hold_done", 64'(done_a), 64'd1);
    chk("hold_ready_done", 64'(ready_a), 64'd0);
    step();
    chk("hold_ready", 64'(ready_a), 64'd1);
    chk("hold_gap_ov", 64'(ov_a), 64'd0);
    step();
    pat_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("second_ov", 64'(ov_a), 64'd1);
      chk("second_o", 64'(o_a), 64'd1);
      step();
    end
    chk("second_done", 64'(done_a), 64'd1);
    step();

    // Reset mid-SHIFT takes effect before the next edge
    wait_ready();
    pat_data = 8'hFF; pat_len = 4'd8; pat_rep = 4'd0; pat_valid = 1'b1;
    step();
    pat_valid = 1'b0;
    step();
    chk("pre_rst_ov", 64'(ov_a), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_o", 64'(o_a), 64'd0);
    chk("mid_rst_ov", 64'(ov_a), 64'd0);
    chk("mid_rst_busy", 64'(busy_a), 64'd0);
    chk("mid_rst_ready", 64'(ready_a), 64'd1);
    chk("mid_rst_done", 64'(done_a), 64'd0);
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("post_rst_done", 64'(done_a), 64'd0);
    end

`ifdef SEQ_PATTERN_TX_ABORT_EN
    // Abort on the second bit returns to IDLE with no done pulse
    wait_ready();
    pat_data = 8'hAA; pat_len = 4'd8; pat_rep = 4'd0; pat_valid = 1'b1;
    step();
    pat_valid = 1'b0;
    chk("ab_bit1", 64'(o_a), 64'd1);
    step();
    chk("ab_bit2", 64'(o_a), 64'd0);
    chk("ab_bit2_ov", 64'(ov_a), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_ov", 64'(ov_a), 64'd0);
    chk("ab_busy", 64'(busy_a), 64'd0);
    chk("ab_ready", 64'(ready_a), 64'd1);
    chk("ab_done", 64'(done_a), 64'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("ab_no_done", 64'(done_a), 64'd0);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
